// File: rtl/aabb_ray_dispatcher_if.sv
// Ray stream from the RayGenerationUnit and the shared push bus to the AABB lane FIFOs.
interface aabb_ray_dispatcher_if #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned WORD_W = 32
);
    logic              iRayValid;
    logic [WORD_W-1:0] iRayData;
    logic              oRayReady;
    logic [LANES-1:0]  oFifoPush;
    logic [WORD_W-1:0] oFifoData;
    logic [LANES-1:0]  iFifoFull;

    // Dispatcher side
    modport master (
        input  iRayValid, iRayData, iFifoFull,
        output oRayReady, oFifoPush, oFifoData
    );

    // RGU / lane FIFO side
    modport slave (
        output iRayValid, iRayData, iFifoFull,
        input  oRayReady, oFifoPush, oFifoData
    );
endinterface

// File: rtl/aabb_ray_dispatcher.sv
// Round-robin dispatcher: steers each complete ray (RAY_WORDS words) to one
// enabled, non-full AABB lane FIFO; a ray is never split across lanes.
module aabb_ray_dispatcher #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned RAY_WORDS = 6,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iEnable,
    input  logic [LANES-1:0]      iLaneEnable,
    input  logic                  iClearCount,
    aabb_ray_dispatcher_if.master bus,
    output logic                  oBusy,
    output logic [2:0]            oLane,
    output logic [CNT_W-1:0]      oRayCount
);

    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned IDX_W  = $clog2(RAY_WORDS);

    typedef enum logic [0:0] {
        IDLE,
        STREAM
    } state_t;

    state_t             state, stateNext;
    logic [IDX_W-1:0]   rIdx, idxNext;
    logic [LANE_W-1:0]  rPtr, ptrNext;
    logic [LANE_W-1:0]  rLane, laneNext;
    logic [CNT_W-1:0]   rCount, countNext;

    logic               candFound;
    logic [LANE_W-1:0]  candLane;
    logic [LANE_W-1:0]  pushLane;
    logic               rayReady;
    logic               transfer;

    // Lane reached by stepping forward from base, wrapping modulo LANES
    function automatic logic [LANE_W-1:0] wrapLane(logic [LANE_W-1:0] base, int unsigned step);
        return LANE_W'((32'(base) + step) % LANES);
    endfunction

    // Round-robin search for the first eligible lane after the last grant
    always_comb begin
        candFound = 1'b0;
        candLane  = '0;
        for (int unsigned k = 1; k <= LANES; k++) begin
            if (!candFound && iLaneEnable[wrapLane(rPtr, k)] && !bus.iFifoFull[wrapLane(rPtr, k)]) begin
                candFound = 1'b1;
                candLane  = wrapLane(rPtr, k);
            end
        end
    end

    // Next-state, handshake and counter logic
    always_comb begin
        stateNext = state;
        idxNext   = rIdx;
        ptrNext   = rPtr;
        laneNext  = rLane;
        countNext = rCount;
        rayReady  = 1'b0;
        pushLane  = rLane;
        transfer  = 1'b0;

        case (state)
            IDLE: begin
                rayReady = iEnable & candFound;
                pushLane = candLane;
                transfer = bus.iRayValid & rayReady;
                if (transfer) begin
                    laneNext  = candLane;
                    idxNext   = IDX_W'(1);
                    stateNext = STREAM;
                end
            end
            STREAM: begin
                rayReady = iEnable & ~bus.iFifoFull[rLane];
                transfer = bus.iRayValid & rayReady;
                if (transfer) begin
                    if (rIdx == IDX_W'(RAY_WORDS - 1)) begin
                        idxNext   = '0;
                        ptrNext   = rLane;
                        countNext = rCount + CNT_W'(1);
                        stateNext = IDLE;
                    end else begin
                        idxNext = rIdx + IDX_W'(1);
                    end
                end
            end
            default: stateNext = IDLE;
        endcase

        // Clear wins over a same-cycle increment
        if (iClearCount) begin
            countNext = '0;
        end
    end

    // State register
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state  <= IDLE;
            rIdx   <= '0;
            rPtr   <= LANE_W'(LANES - 1);
            rLane  <= '0;
            rCount <= '0;
        end else begin
            state  <= stateNext;
            rIdx   <= idxNext;
            rPtr   <= ptrNext;
            rLane  <= laneNext;
            rCount <= countNext;
        end
    end

    // Zero-latency pass-through to the shared FIFO bus
    assign bus.oRayReady = rayReady;
    assign bus.oFifoData = WORD_W'(bus.iRayData);
    assign bus.oFifoPush = transfer ? (LANES'(1) << pushLane) : '0;

    // Status readback
    assign oBusy     = (state == STREAM);
    assign oLane     = 3'(rLane);
    assign oRayCount = rCount;

endmodule

// File: tb/tb_aabb_ray_dispatcher.sv
// Randomized and directed bench for aabb_ray_dispatcher against a ray-level reference model.
module tb_aabb_ray_dispatcher;

    localparam int unsigned LANES     = 2;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned RAY_WORDS = 6;
    localparam int unsigned CNT_W     = 16;

    logic             clk;
    logic             rstN;
    logic             en;
    logic [LANES-1:0] laneEn;
    logic             clr;
    logic             busy;
    logic [2:0]       lane;
    logic [CNT_W-1:0] rayCount;

    aabb_ray_dispatcher_if #(.LANES(LANES), .WORD_W(WORD_W)) bus ();

    aabb_ray_dispatcher #(
        .LANES(LANES), .WORD_W(WORD_W), .RAY_WORDS(RAY_WORDS), .CNT_W(CNT_W)
    ) dut (
        .iClock(clk),
        .iReset(rstN),
        .iEnable(en),
        .iLaneEnable(laneEn),
        .iClearCount(clr),
        .bus(bus),
        .oBusy(busy),
        .oLane(lane),
        .oRayCount(rayCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model: which lane holds the ray in flight and how far it got
    bit               mBusy;
    int               mLane;
    int               mPtr;
    int               mWords;
    logic [CNT_W-1:0] mCount;

    int obsPush[LANES];
    int readyLow;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mBusy  = 1'b0;
        mLane  = 0;
        mPtr   = LANES - 1;
        mWords = 0;
        mCount = '0;
    endtask

    task automatic clearTally();
        for (int i = 0; i < LANES; i++) obsPush[i] = 0;
        readyLow = 0;
    endtask

    // First eligible lane after the last granted one, or -1
    function automatic int pickLane(input int ptr, input logic [LANES-1:0] le, input logic [LANES-1:0] fu);
        for (int k = 1; k <= LANES; k++) begin
            int j;
            j = (ptr + k) % LANES;
            if (le[j] && !fu[j]) return j;
        end
        return -1;
    endfunction

    // One clock: called at posedge+1 with inputs already applied
    task automatic runCycle();
        int               cand;
        int               useLane;
        logic             expReady;
        logic             xfer;
        logic [LANES-1:0] expPush;
        #1;
        cand = pickLane(mPtr, laneEn, bus.iFifoFull);
        if (!en)        expReady = 1'b0;
        else if (mBusy) expReady = !bus.iFifoFull[mLane];
        else            expReady = (cand >= 0);
        useLane = mBusy ? mLane : cand;
        xfer    = bus.iRayValid && expReady;
        expPush = xfer ? (LANES'(1) << useLane) : '0;

        checkVal("ready", 64'(bus.oRayReady), 64'(expReady));
        checkVal("push",  64'(bus.oFifoPush), 64'(expPush));
        if (xfer) checkVal("data", 64'(bus.oFifoData), 64'(bus.iRayData));
        checkVal("busy",  64'(busy), 64'(mBusy));
        checkVal("lane",  64'(lane), 64'(mLane));
        checkVal("count", 64'(rayCount), 64'(mCount));

        for (int i = 0; i < LANES; i++) if (bus.oFifoPush[i]) obsPush[i]++;
        if (!bus.oRayReady) readyLow++;

        @(posedge clk);
        if (xfer) begin
            if (!mBusy) begin
                mBusy  = 1'b1;
                mLane  = useLane;
                mWords = 1;
            end else begin
                mWords++;
            end
            if (mWords == RAY_WORDS) begin
                mBusy  = 1'b0;
                mPtr   = mLane;
                mWords = 0;
                mCount = mCount + 1'b1;
            end
        end
        if (clr) mCount = '0;
        #1;
    endtask

    task automatic stream(input int n);
        bus.iRayValid = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.iRayData = $urandom;
            runCycle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rstN          = 1'b0;
        en            = 1'b1;
        laneEn        = '1;
        clr           = 1'b0;
        bus.iRayValid = 1'b0;
        bus.iRayData  = '0;
        bus.iFifoFull = '0;
        modelReset();
        clearTally();

        // Reset state
        @(posedge clk); #1;
        checkVal("rst_busy",  64'(busy), 64'(0));
        checkVal("rst_lane",  64'(lane), 64'(0));
        checkVal("rst_count", 64'(rayCount), 64'(0));
        checkVal("rst_push",  64'(bus.oFifoPush), 64'(0));
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); #1;

        // Four back-to-back rays alternate lanes with no bubble
        clearTally();
        stream(24);
        checkVal("rr_lane0", 64'(obsPush[0]), 64'(12));
        checkVal("rr_lane1", 64'(obsPush[1]), 64'(12));
        checkVal("rr_count", 64'(rayCount), 64'(4));
        checkVal("rr_nostall", 64'(readyLow), 64'(0));

        // Lane 0 masked off: everything on lane 1
        bus.iRayValid = 1'b0;
        clr = 1'b1;
        runCycle();
        clr = 1'b0;
        laneEn = 2'b10;
        clearTally();
        stream(12);
        checkVal("mask_lane0", 64'(obsPush[0]), 64'(0));
        checkVal("mask_lane1", 64'(obsPush[1]), 64'(12));
        checkVal("mask_count", 64'(rayCount), 64'(2));

        // Full flag mid-ray stalls without moving the ray
        laneEn = 2'b11;
        clearTally();
        stream(3);
        bus.iFifoFull = 2'b01;
        for (int i = 0; i < 5; i++) begin
            stream(1);
            checkVal("full_busy", 64'(busy), 64'(1));
        end
        bus.iFifoFull = '0;
        stream(3);
        checkVal("full_lane0", 64'(obsPush[0]), 64'(6));
        checkVal("full_lane1", 64'(obsPush[1]), 64'(0));
        checkVal("full_stalls", 64'(readyLow), 64'(5));

        // Mask drop mid-ray keeps the locked lane; later rays avoid it
        stream(6);
        clearTally();
        stream(2);
        laneEn = 2'b10;
        stream(4);
        stream(12);
        checkVal("drop_lane0", 64'(obsPush[0]), 64'(6));
        checkVal("drop_lane1", 64'(obsPush[1]), 64'(12));

        // Enable low freezes the ray mid-stream
        laneEn = 2'b11;
        clearTally();
        stream(2);
        en = 1'b0;
        stream(3);
        en = 1'b1;
        stream(4);
        checkVal("en_pushes", 64'(obsPush[0] + obsPush[1]), 64'(6));
        checkVal("en_idle", 64'(busy), 64'(0));

        // Asynchronous reset mid-ray
        stream(4);
        bus.iRayValid = 1'b0;
        rstN = 1'b0;
        #1;
        checkVal("mrst_busy",  64'(busy), 64'(0));
        checkVal("mrst_count", 64'(rayCount), 64'(0));
        checkVal("mrst_lane",  64'(lane), 64'(0));
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); #1;
        clearTally();
        stream(6);
        checkVal("mrst_lane0", 64'(obsPush[0]), 64'(6));

        // Clear on the last word of a ray wins over the increment
        stream(5);
        clr = 1'b1;
        stream(1);
        clr = 1'b0;
        checkVal("clr_last", 64'(rayCount), 64'(0));

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            bus.iRayValid = ($urandom_range(3) != 0);
            bus.iRayData  = $urandom;
            en            = ($urandom_range(9) != 0);
            if ($urandom_range(15) == 0) laneEn = LANES'($urandom);
            for (int i = 0; i < LANES; i++) bus.iFifoFull[i] = ($urandom_range(3) == 0);
            clr           = ($urandom_range(31) == 0);
            runCycle();
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
